fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 The block SHALL have parameter HALF, default 64, giving the delay-line length and half-frame size; the frame is 2*HALF samples.
REQ-002 The block SHALL have parameter AW, default 6, giving the twiddle address width, with log2(HALF) = AW.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  sample present on the datapath input.
REQ-007 Port: flush  input  1  single-cycle request to drain the delay line after the current frame.
REQ-008 Port: in_ready  output  1  controller accepts a sample; a sample is accepted when in_valid && in_ready.
REQ-009 Port: state  output  2  datapath mode: 0 FILL, 1 BUTTERFLY, 2 TWIDDLE; 3 is never driven.
REQ-010 Port: tw_addr  output  AW  twiddle ROM address.
REQ-011 Port: out_valid  output  1  datapath output sample valid.
REQ-012 Port: frame_done  output  1  single-cycle pulse at the end of each frame.
REQ-013 Port: busy  output  1  controller holds live data.
REQ-014 Port: frame_cnt  output  8  number of completed frames, saturating.

Function
REQ-015 The block SHALL keep an internal sample index idx (AW+1 bits) that increments on each accepted sample and wraps from 2*HALF-1 to 0.
REQ-016 The block SHALL keep a primed flag that is set on the first wrap of idx and cleared only at the end of a drain or by reset.
REQ-017 All outputs SHALL be registered; an accepted sample in cycle t produces its state, tw_addr and out_valid in cycle t+1.
REQ-018 Mode selection for an accepted sample SHALL be:
  - idx >= HALF: BUTTERFLY, tw_addr = 0, out_valid = 1.
  - idx < HALF and primed: TWIDDLE, tw_addr = idx[AW-1:0], out_valid = 1.
  - idx < HALF and not primed: FILL, tw_addr = 0, out_valid = 0.
REQ-019 In a cycle with no accepted sample and no drain step, out_valid SHALL be 0 in the next cycle, while state and tw_addr hold their previous values.
REQ-020 frame_done SHALL pulse in the cycle after the sample with idx = 2*HALF-1 is accepted.
REQ-021 frame_cnt SHALL increment on each such wrap and saturate at 255.
REQ-022 flush SHALL set a pending flag when primed and not draining; flush while unprimed or while draining SHALL be ignored.
REQ-023 When pending is set and idx = 0, the block SHALL enter DRAIN:
  - in_ready = 0 for HALF cycles.
  - Drain step d (0..HALF-1) drives state = 2, tw_addr = d and out_valid = 1, one cycle later.
REQ-024 After drain step HALF-1, the block SHALL drive state = 0 and in_ready = 1, and SHALL clear primed and pending.
REQ-025 flush raised mid-frame (idx != 0) SHALL stay pending; samples SHALL continue to be accepted until idx wraps, and DRAIN SHALL start in the cycle after the wrap.
REQ-026 flush and an accepted sample at idx = 2*HALF-1 in the same cycle SHALL accept the sample, pulse frame_done, and deassert in_ready in the next cycle.
REQ-027 in_valid during DRAIN SHALL be ignored and SHALL leave idx unchanged.
REQ-028 busy SHALL equal (idx != 0) || primed || pending || draining.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL set:
  - state = 0, tw_addr = 0, out_valid = 0, frame_done = 0, busy = 0, frame_cnt = 0, in_ready = 1.
  - idx = 0, and clear primed, pending and draining.
REQ-030 Reset asserted mid-frame or mid-drain SHALL abandon the operation with no further out_valid, and the first accepted sample after reset SHALL be FILL with idx = 0.

Verification
REQ-031 First frame: after reset, drive 128 consecutive in_valid cycles. Required: 64 outputs with state = 0 and out_valid = 0, then 64 with state = 1 and out_valid = 1; frame_done pulses once; frame_cnt = 1.
REQ-032 Second frame: continue with 64 more samples. Required: state = 2, tw_addr = 0,1,...,63 and out_valid = 1 on each.
REQ-033 Gapped input: drive in_valid on alternate cycles. Required: idx advances only on accepted cycles, out_valid is high on alternate cycles, and tw_addr holds its value through the gaps.
REQ-034 Flush at frame end: assert flush together with sample idx = 127 of frame 2. Required:
  - frame_done pulses, then in_ready = 0 for 64 cycles with tw_addr = 0..63 and out_valid = 1.
  - After the drain: state = 0, in_ready = 1, busy = 0, frame_cnt = 2.
REQ-035 Ignored and deferred flush: assert flush before the first wrap. Required: no drain occurs. Then assert flush at idx = 70 of frame 2. Required: the drain starts exactly one cycle after the idx = 127 acceptance.
REQ-036 Reset mid-drain: assert rst at drain step 30. Required: all outputs and frame_cnt are at their reset values in the next cycle, and the next sample is FILL.

Source files
------------

// File: rtl/fft_stage_ctrl_if.sv
// Sample handshake and status bundle between a sample source (master) and the
// FFT stage controller (slave).
interface fft_stage_ctrl_if #(
   parameter int AW = 6
);
   logic          in_valid;
   logic          flush;
   logic          in_ready;
   logic [1:0]    state;
   logic [AW-1:0] tw_addr;
   logic          out_valid;
   logic          frame_done;
   logic          busy;
   logic [7:0]    frame_cnt;

   modport master (
      output in_valid,
      output flush,
      input  in_ready,
      input  state,
      input  tw_addr,
      input  out_valid,
      input  frame_done,
      input  busy,
      input  frame_cnt
   );

   modport slave (
      input  in_valid,
      input  flush,
      output in_ready,
      output state,
      output tw_addr,
      output out_valid,
      output frame_done,
      output busy,
      output frame_cnt
   );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Radix-2 delay-line FFT stage controller: sequences FILL/BUTTERFLY/TWIDDLE
// modes per sample, counts frames and drains the delay line on request.
module fft_stage_ctrl #(
   parameter int HALF = 64,
   parameter int AW   = 6
) (
   input  logic            clk,
   input  logic            rst,
   fft_stage_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_FILL = 2'd0,
      MODE_BFLY = 2'd1,
      MODE_TWID = 2'd2
   } mode_e;

   // PH_END is the single cycle after the last drain step that parks state at FILL.
   typedef enum logic [1:0] {
      PH_RUN   = 2'd0,
      PH_DRAIN = 2'd1,
      PH_END   = 2'd2
   } phase_e;

   localparam logic [AW:0]   IDX_ZERO  = '0;
   localparam logic [AW:0]   IDX_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   IDX_HALF  = (AW+1)'(HALF);
   localparam logic [AW:0]   IDX_LAST  = (AW+1)'(2*HALF-1);
   localparam logic [AW-1:0] STEP_ONE  = AW'(1);
   localparam logic [AW-1:0] STEP_LAST = AW'(HALF-1);

   logic [AW:0]   idx_q, idx_d;
   logic          primed_q, primed_d;
   logic          pending_q, pending_d;
   phase_e        phase_q, phase_d;
   logic [AW-1:0] dstep_q, dstep_d;

   mode_e         state_q, state_d;
   logic [AW-1:0] tw_q, tw_d;
   logic          out_valid_q, out_valid_d;
   logic          frame_done_q, frame_done_d;
   logic          busy_q, busy_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          in_ready_q, in_ready_d;

   logic          accept;
   logic          wrap;

   always_comb begin
      accept       = bus.in_valid && in_ready_q;
      wrap         = accept && (idx_q == IDX_LAST);

      idx_d        = idx_q;
      primed_d     = primed_q;
      pending_d    = pending_q;
      phase_d      = phase_q;
      dstep_d      = dstep_q;
      state_d      = state_q;
      tw_d         = tw_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      in_ready_d   = in_ready_q;

      case (phase_q)
         PH_RUN, PH_END: begin
            if (phase_q == PH_END) begin
               state_d = MODE_FILL;
               tw_d    = '0;
               phase_d = PH_RUN;
            end

            if (accept) begin
               idx_d = wrap ? IDX_ZERO : (idx_q + IDX_ONE);
               if (idx_q >= IDX_HALF) begin
                  state_d     = MODE_BFLY;
                  tw_d        = '0;
                  out_valid_d = 1'b1;
               end else if (primed_q) begin
                  state_d     = MODE_TWID;
                  tw_d        = idx_q[AW-1:0];
                  out_valid_d = 1'b1;
               end else begin
                  state_d     = MODE_FILL;
                  tw_d        = '0;
                  out_valid_d = 1'b0;
               end
            end

            if (wrap) begin
               primed_d     = 1'b1;
               frame_done_d = 1'b1;
               if (frame_cnt_q != 8'hFF) begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end

            // Flush only means something once the delay line holds a full half-frame.
            if (bus.flush && primed_q) begin
               pending_d = 1'b1;
            end

            if (pending_d && (idx_d == IDX_ZERO)) begin
               phase_d    = PH_DRAIN;
               dstep_d    = '0;
               in_ready_d = 1'b0;
            end
         end

         PH_DRAIN: begin
            state_d     = MODE_TWID;
            tw_d        = dstep_q;
            out_valid_d = 1'b1;
            if (dstep_q == STEP_LAST) begin
               phase_d    = PH_END;
               in_ready_d = 1'b1;
               primed_d   = 1'b0;
               pending_d  = 1'b0;
            end else begin
               dstep_d = dstep_q + STEP_ONE;
            end
         end

         default: begin
            phase_d    = PH_RUN;
            in_ready_d = 1'b1;
         end
      endcase

      busy_d = (idx_d != IDX_ZERO) || primed_d || pending_d || (phase_d == PH_DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q        <= '0;
         primed_q     <= 1'b0;
         pending_q    <= 1'b0;
         phase_q      <= PH_RUN;
         dstep_q      <= '0;
         state_q      <= MODE_FILL;
         tw_q         <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_cnt_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         idx_q        <= idx_d;
         primed_q     <= primed_d;
         pending_q    <= pending_d;
         phase_q      <= phase_d;
         dstep_q      <= dstep_d;
         state_q      <= state_d;
         tw_q         <= tw_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         frame_cnt_q  <= frame_cnt_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.state      = state_q;
   assign bus.tw_addr    = tw_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = busy_q;
   assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: directed frame/flush/reset scenarios plus random
// traffic, every cycle compared against a sample-level reference model.
module tb_fft_stage_ctrl;
   localparam int HALF = 64;
   localparam int AW   = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft_stage_ctrl_if #(.AW(AW)) bus_if ();

   fft_stage_ctrl #(.HALF(HALF), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: sample index, flags and remaining drain steps as plain integers.
   int m_idx;
   bit m_primed, m_pending, m_post;
   int m_drain_left;
   int m_frames;
   int e_state, e_tw;
   bit e_ov, e_fd, e_rdy, e_busy;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_idx = 0; m_primed = 0; m_pending = 0; m_post = 0;
      m_drain_left = 0; m_frames = 0;
      e_state = 0; e_tw = 0; e_ov = 0; e_fd = 0; e_rdy = 1; e_busy = 0;
   endtask

   task automatic model_step(input bit v, input bit f);
      bit was_primed;
      e_ov = 0;
      e_fd = 0;
      if (m_drain_left > 0) begin
         e_state = 2;
         e_tw    = HALF - m_drain_left;
         e_ov    = 1;
         m_drain_left--;
         if (m_drain_left == 0) begin
            m_primed = 0; m_pending = 0; m_post = 1;
         end
      end else begin
         if (m_post) begin
            e_state = 0; e_tw = 0; m_post = 0;
         end
         was_primed = m_primed;
         if (v) begin
            if (m_idx >= HALF) begin
               e_state = 1; e_tw = 0; e_ov = 1;
            end else if (m_primed) begin
               e_state = 2; e_tw = m_idx; e_ov = 1;
            end else begin
               e_state = 0; e_tw = 0; e_ov = 0;
            end
            m_idx++;
            if (m_idx == 2*HALF) begin
               m_idx = 0; e_fd = 1; m_primed = 1;
               if (m_frames < 255) m_frames++;
            end
         end
         if (f && was_primed) m_pending = 1;
         if (m_pending && m_idx == 0) m_drain_left = HALF;
      end
      e_rdy  = (m_drain_left == 0);
      e_busy = (m_idx != 0) || m_primed || m_pending || (m_drain_left > 0);
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".state"},      32'(bus_if.state),      32'(e_state));
      check_eq({tag, ".tw_addr"},    32'(bus_if.tw_addr),    32'(e_tw));
      check_eq({tag, ".out_valid"},  32'(bus_if.out_valid),  32'(e_ov));
      check_eq({tag, ".frame_done"}, 32'(bus_if.frame_done), 32'(e_fd));
      check_eq({tag, ".in_ready"},   32'(bus_if.in_ready),   32'(e_rdy));
      check_eq({tag, ".busy"},       32'(bus_if.busy),       32'(e_busy));
      check_eq({tag, ".frame_cnt"},  32'(bus_if.frame_cnt),  32'(m_frames));
   endtask

   task automatic cyc(input bit v, input bit f, input string tag);
      bus_if.in_valid = v;
      bus_if.flush    = f;
      model_step(v, f);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.flush    = 1'b1;
      @(posedge clk);
      #1;
      rst             = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.flush    = 1'b0;
      model_reset();
      check_all("rst");
   endtask

   initial begin
      int lows;
      int fd_seen;
      rst             = 1'b1;
      bus_if.in_valid = 1'b0;
      bus_if.flush    = 1'b0;

      // Scenario A: ignored flush in frame 1, gapped input, flush deferred from idx 70
      do_reset();
      check_eq("A.rst.in_ready", 32'(bus_if.in_ready), 1);
      check_eq("A.rst.busy",     32'(bus_if.busy), 0);
      lows = 0; fd_seen = 0;
      for (int i = 0; i < 2*HALF; i++) begin
         cyc(1'b1, (i == 10), "A.f1");
         if (!bus_if.in_ready) lows++;
         if (bus_if.frame_done) fd_seen++;
      end
      check_eq("A.f1.no_drain", 32'(lows), 0);
      check_eq("A.f1.fd_pulses", 32'(fd_seen), 1);
      check_eq("A.f1.frame_cnt", 32'(bus_if.frame_cnt), 1);
      for (int i = 0; i < HALF; i++) begin
         cyc(1'b1, 1'b0, "A.f2tw");
         check_eq("A.f2tw.seq", 32'(bus_if.tw_addr), 32'(i));
      end
      for (int i = 0; i < 12; i++) begin
         cyc((i % 2) == 0, 1'b0, "A.gap");
         check_eq("A.gap.ov", 32'(bus_if.out_valid), 32'((i % 2) == 0));
      end
      cyc(1'b1, 1'b1, "A.fl70");
      for (int i = 71; i < 2*HALF; i++) cyc(1'b1, 1'b0, "A.f2b");
      check_eq("A.drain_start", 32'(bus_if.in_ready), 0);
      lows = 1;
      for (int i = 0; i < HALF; i++) begin
         cyc(1'b1, 1'b0, "A.drain");
         if (!bus_if.in_ready) lows++;
      end
      check_eq("A.drain_len", 32'(lows), 32'(HALF));
      cyc(1'b0, 1'b0, "A.post");
      cyc(1'b0, 1'b0, "A.post");
      check_eq("A.post.state", 32'(bus_if.state), 0);
      check_eq("A.post.busy",  32'(bus_if.busy), 0);
      check_eq("A.post.cnt",   32'(bus_if.frame_cnt), 2);

      // Scenario B: flush together with the last sample of frame 2
      do_reset();
      for (int i = 0; i < 4*HALF-1; i++) cyc(1'b1, 1'b0, "B.run");
      cyc(1'b1, 1'b1, "B.fl127");
      check_eq("B.fd", 32'(bus_if.frame_done), 1);
      check_eq("B.rdy_low", 32'(bus_if.in_ready), 0);
      lows = 1;
      for (int k = 1; k <= HALF; k++) begin
         cyc(1'b0, 1'b0, "B.drain");
         check_eq("B.drain.tw", 32'(bus_if.tw_addr), 32'(k-1));
         check_eq("B.drain.ov", 32'(bus_if.out_valid), 1);
         if (!bus_if.in_ready) lows++;
      end
      check_eq("B.drain_len", 32'(lows), 32'(HALF));
      cyc(1'b0, 1'b0, "B.post");
      check_eq("B.post.state", 32'(bus_if.state), 0);
      check_eq("B.post.rdy",   32'(bus_if.in_ready), 1);
      check_eq("B.post.busy",  32'(bus_if.busy), 0);
      check_eq("B.post.cnt",   32'(bus_if.frame_cnt), 2);

      // Scenario C: reset at drain step 30, then first sample must be FILL
      do_reset();
      for (int i = 0; i < 4*HALF-1; i++) cyc(1'b1, 1'b0, "C.run");
      cyc(1'b1, 1'b1, "C.fl127");
      for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, "C.drain");
      do_reset();
      check_eq("C.rst.ov",   32'(bus_if.out_valid), 0);
      check_eq("C.rst.cnt",  32'(bus_if.frame_cnt), 0);
      check_eq("C.rst.rdy",  32'(bus_if.in_ready), 1);
      check_eq("C.rst.tw",   32'(bus_if.tw_addr), 0);
      cyc(1'b1, 1'b0, "C.first");
      check_eq("C.first.state", 32'(bus_if.state), 0);
      check_eq("C.first.ov",    32'(bus_if.out_valid), 0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, "C.idle");

      // Scenario D: random valid/flush traffic with occasional reset
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         else cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3, "D.rand");
      end

      // Scenario E: frame counter saturation
      do_reset();
      for (int i = 0; i < 258*2*HALF; i++) cyc(1'b1, 1'b0, "E.sat");
      check_eq("E.sat.cnt", 32'(bus_if.frame_cnt), 255);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
